irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//   Interrupt controller feeding the picorv32 irq/eoi pins: latches NUM_SRC external sources into PENDING,
//   masks with ENABLE, drives irq to the core, clears on the core's eoi acknowledge.
//   Also a memory-bus responder on the core's native mem_* interface (beside the SRAM) for SW register access.
//   SOC muxes mem_ready/mem_rdata between SRAM and this block using sel.
// PARAMETERS
//   NUM_SRC    16             number of interrupt sources (1..32)
//   BASE_ADDR  32'h1000_0000  register window base address
//   ADDR_MASK  32'hFFFF_F000  address bits compared against BASE_ADDR
// PORTS
//   clk        in   1        single clock; all logic rising-edge
//   rst        in   1        synchronous, active-high reset
//   src        in   NUM_SRC  external interrupt requests, synchronous to clk
//   irq        out  NUM_SRC  to core irq[NUM_SRC-1:0]; = PENDING & ENABLE, registered
//   eoi        in   NUM_SRC  from core eoi; rising edge = acknowledge
//   mem_valid  in   1        core bus request
//   mem_addr   in   32       byte address
//   mem_wdata  in   32       write data
//   mem_wstrb  in   4        byte strobes; 4'h0 = read
//   sel        out  1        combinational: mem_valid && (mem_addr & ADDR_MASK)==BASE_ADDR
//   mem_ready  out  1        one-cycle response pulse
//   mem_rdata  out  32       read data, valid only with mem_ready, else 32'h0
// BEHAVIOUR
//   Reset (rst=1 at edge): PENDING=0, ENABLE=0, TRIGGER=0, irq=0, mem_ready=0, mem_rdata=0, edge regs=0.
//   Register map (offset = mem_addr[4:2]*4; others read 0, writes ignored, still ready):
//     0x00 PENDING  R / W1C     0x04 ENABLE  RW     0x08 ACTIVE  R (= current irq)
//     0x0C TRIGGER  RW (opt)    0x10 SWSET   W (write-1 sets PENDING; reads 0)
//   Writes honour mem_wstrb per byte; bits >= NUM_SRC read 0.
//   Bus: FSM IDLE -> RESP -> WAIT.
//     IDLE: sel=1 -> perform write / capture read data this edge -> RESP.
//     RESP: mem_ready=1 for exactly one cycle, mem_rdata driven -> WAIT.
//     WAIT: wait for mem_valid=0 (one transaction per valid) -> IDLE. Latency: ready 1 cycle after request.
//   Read returns register value sampled at request edge (pre-update).
//   PENDING set on src rising edge (src & ~src_q) or SWSET bit; cleared by W1C bit or eoi rising edge.
//   Simultaneous set and clear on same bit in same cycle: set wins (no lost interrupt).
//   irq registered: irq = PENDING & ENABLE one cycle after PENDING changes; ENABLE=0 does not clear PENDING.
//   rst mid-transaction: FSM -> IDLE, no mem_ready pulse for the aborted access.
// CONFIGURATION
//   IRQ_CTRL_LEVEL_EN defined: TRIGGER register present; TRIGGER[i]=1 -> level source:
//     PENDING[i] = src[i] each cycle (W1C/eoi ineffective while src high); 0 -> edge as above.
//   Not defined: all sources edge-triggered; 0x0C reads 0, writes ignored; no TRIGGER flops.
// STRUCTURE
//   irq_ctrl_pkg: register offset localparams (OFF_PENDING..OFF_SWSET), bus FSM state enum typedef.
//   Sub-module irq_ctrl_edge: per-bit rising-edge detector (src_q register), instantiated for src and eoi.
// TESTING
//   Reset, read 0x04 -> mem_ready exactly 1 cycle after mem_valid, rdata 0; sel=0 for 0x0000_0000.
//   Write ENABLE=0x0001; pulse src[0] one cycle -> PENDING[0]=1, irq[0]=1 next cycle; read 0x00 -> 0x0001.
//   With irq[0] high, raise eoi[0] -> PENDING[0]=0, irq[0]=0 next cycle; held eoi does not re-clear new edge.
//   ENABLE=0, src[3] edge -> irq stays 0, PENDING=0x0008; then ENABLE=0x0008 -> irq[3]=1.
//   Same cycle src[5] rising edge and W1C 0x0020 -> PENDING[5] stays 1; SWSET 0x0100 -> PENDING[8]=1.
//   LEVEL_EN: TRIGGER=0x0002, hold src[1]=1, W1C 0x0002 -> PENDING[1] stays 1; drop src[1] -> 0.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared register offsets and bus-responder state encoding for the interrupt controller.
package irq_ctrl_pkg;

    localparam logic [4:0] OFF_PENDING = 5'h00;
    localparam logic [4:0] OFF_ENABLE  = 5'h04;
    localparam logic [4:0] OFF_ACTIVE  = 5'h08;
    localparam logic [4:0] OFF_TRIGGER = 5'h0C;
    localparam logic [4:0] OFF_SWSET   = 5'h10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESP,
        ST_WAIT
    } bus_state_t;

endpackage

// File: rtl/irq_ctrl_edge.sv
// Per-bit rising-edge detector: rise is high in the cycle where d goes 0 -> 1.
module irq_ctrl_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise
);

    logic [W-1:0] d_q;

    always_ff @(posedge clk) begin
        if (rst) d_q <= '0;
        else     d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller for the picorv32 irq/eoi pins with a mem_* bus register window.
// Optional level-triggered sources are compiled in with `define IRQ_CTRL_LEVEL_EN.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int          NUM_SRC   = 16,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_F000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src,
    output logic [NUM_SRC-1:0] irq,
    input  logic [NUM_SRC-1:0] eoi,
    input  logic               mem_valid,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    input  logic [3:0]         mem_wstrb,
    output logic               sel,
    output logic               mem_ready,
    output logic [31:0]        mem_rdata
);

    bus_state_t         state, state_n;
    logic               access, is_write;
    logic [4:0]         offset;
    logic [NUM_SRC-1:0] wmask, wval;
    logic [NUM_SRC-1:0] pending, pending_n, enable, trigger;
    logic [NUM_SRC-1:0] src_rise, eoi_rise, set_v, clr_v;
    logic               wr_pending, wr_enable, wr_swset;
    logic [31:0]        rd_val, rdata_q;
    logic               unused_wdata;

    function automatic logic [31:0] ext(input logic [NUM_SRC-1:0] v);
        logic [31:0] r;
        r = '0;
        r[NUM_SRC-1:0] = v;
        return r;
    endfunction

    assign sel      = mem_valid && ((mem_addr & ADDR_MASK) == BASE_ADDR);
    assign access   = (state == ST_IDLE) && sel;
    assign is_write = |mem_wstrb;
    assign offset   = {mem_addr[4:2], 2'b00};

    // Register bits above NUM_SRC do not exist, so the upper write data is dropped.
    assign unused_wdata = ^mem_wdata;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_wmask
        assign wmask[g] = mem_wstrb[g / 8];
    end
    assign wval = mem_wdata[NUM_SRC-1:0] & wmask;

    assign wr_pending = access && is_write && (offset == OFF_PENDING);
    assign wr_enable  = access && is_write && (offset == OFF_ENABLE);
    assign wr_swset   = access && is_write && (offset == OFF_SWSET);

    irq_ctrl_edge #(.W(NUM_SRC)) u_src_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (src),
        .rise (src_rise)
    );

    irq_ctrl_edge #(.W(NUM_SRC)) u_eoi_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (eoi),
        .rise (eoi_rise)
    );

`ifdef IRQ_CTRL_LEVEL_EN
    logic wr_trigger;
    assign wr_trigger = access && is_write && (offset == OFF_TRIGGER);

    always_ff @(posedge clk) begin
        if (rst)             trigger <= '0;
        else if (wr_trigger) trigger <= (trigger & ~wmask) | wval;
    end
`else
    assign trigger = '0;
`endif

    // Set is OR-ed in after clear so a coincident set never loses an interrupt.
    always_comb begin
        set_v     = src_rise | (wr_swset ? wval : '0);
        clr_v     = eoi_rise | (wr_pending ? wval : '0);
        pending_n = (pending & ~clr_v) | set_v;
`ifdef IRQ_CTRL_LEVEL_EN
        pending_n = (pending_n & ~trigger) | (src & trigger);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            enable  <= '0;
            irq     <= '0;
        end else begin
            pending <= pending_n;
            irq     <= pending & enable;
            if (wr_enable) enable <= (enable & ~wmask) | wval;
        end
    end

    always_comb begin
        rd_val = '0;
        case (offset)
            OFF_PENDING: rd_val = ext(pending);
            OFF_ENABLE:  rd_val = ext(enable);
            OFF_ACTIVE:  rd_val = ext(irq);
            OFF_TRIGGER: rd_val = ext(trigger);
            default:     rd_val = '0;
        endcase
    end

    // Read data is captured on the request edge, before any same-edge write lands.
    always_ff @(posedge clk) begin
        if (rst)                       rdata_q <= '0;
        else if (access && !is_write)  rdata_q <= rd_val;
        else if (access)               rdata_q <= '0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Valid/ready: a request is accepted in IDLE when sel is high; mem_ready pulses
    // for one cycle in RESP, then WAIT holds off until the core drops mem_valid.
    always_comb begin
        state_n   = state;
        mem_ready = 1'b0;
        mem_rdata = '0;
        case (state)
            ST_IDLE: if (sel) state_n = ST_RESP;
            ST_RESP: begin
                mem_ready = 1'b1;
                mem_rdata = rdata_q;
                state_n   = ST_WAIT;
            end
            ST_WAIT: if (!mem_valid) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a vector table of bus/src/eoi operations plus multi-cycle corner sequences.
module tb_irq_ctrl;

    localparam int NS = 16;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int OP_RD  = 0;
    localparam int OP_WR  = 1;
    localparam int OP_SRC = 2;
    localparam int OP_EOI = 3;

    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic [NS-1:0] exp_irq;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] src, eoi, irq;
    logic          mem_valid, sel, mem_ready;
    logic [31:0]   mem_addr, mem_wdata, mem_rdata;
    logic [3:0]    mem_wstrb;

    logic [31:0] exp_q[$];
    vec_t        tbl[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] rd;

    irq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .src       (src),
        .irq       (irq),
        .eoi       (eoi),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .sel       (sel),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus transaction; src_pulse bits are raised in the request cycle only.
    task automatic bus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [NS-1:0] src_pulse,
                       output logic [31:0] rdata);
        int lat;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = data;
        mem_wstrb = wr ? strb : 4'h0;
        src       = src | src_pulse;
        #1;
        check("bus_sel", {31'b0, sel}, 32'h1);
        lat   = 0;
        rdata = '0;
        do begin
            @(negedge clk);
            lat++;
            src = src & ~src_pulse;
        end while (!mem_ready && lat < 8);
        check("bus_latency", lat, 1);
        if (mem_ready) rdata = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        @(negedge clk);
        check("bus_ready_one_cycle", {31'b0, mem_ready}, 32'h0);
    endtask

    task automatic rd_chk(input string name, input logic [4:0] off, input logic [31:0] exp);
        logic [31:0] r;
        exp_q.push_back(exp);
        bus(1'b0, BASE + {27'b0, off}, 32'h0, 4'h0, '0, r);
        check(name, r, exp_q.pop_front());
    endtask

    task automatic wr_reg(input logic [4:0] off, input logic [31:0] data);
        logic [31:0] r;
        bus(1'b1, BASE + {27'b0, off}, data, 4'hF, '0, r);
    endtask

    task automatic add(input int op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [31:0] exp_rd, input logic [NS-1:0] exp_irq);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.strb = strb;
        v.exp_rd = exp_rd; v.exp_irq = exp_irq;
        tbl.push_back(v);
    endtask

    initial begin
        // op, address, data, strobes, expected read data, expected irq after the op
        add(OP_RD,  BASE + 32'h04, 32'h0,         4'h0, 32'h0,      16'h0000);
        add(OP_RD,  BASE + 32'h00, 32'h0,         4'h0, 32'h0,      16'h0000);
        add(OP_WR,  BASE + 32'h04, 32'h0001,      4'hF, 32'h0,      16'h0000);
        add(OP_RD,  BASE + 32'h04, 32'h0,         4'h0, 32'h0001,   16'h0000);
        add(OP_SRC, 32'h0,         32'h0001,      4'h0, 32'h0,      16'h0001);
        add(OP_RD,  BASE + 32'h00, 32'h0,         4'h0, 32'h0001,   16'h0001);
        add(OP_RD,  BASE + 32'h08, 32'h0,         4'h0, 32'h0001,   16'h0001);
        add(OP_EOI, 32'h0,         32'h0001,      4'h0, 32'h0,      16'h0000);
        add(OP_RD,  BASE + 32'h00, 32'h0,         4'h0, 32'h0,      16'h0000);
        add(OP_WR,  BASE + 32'h04, 32'h0000,      4'hF, 32'h0,      16'h0000);
        add(OP_SRC, 32'h0,         32'h0008,      4'h0, 32'h0,      16'h0000);
        add(OP_RD,  BASE + 32'h00, 32'h0,         4'h0, 32'h0008,   16'h0000);
        add(OP_WR,  BASE + 32'h04, 32'h0008,      4'hF, 32'h0,      16'h0008);
        add(OP_WR,  BASE + 32'h00, 32'h0008,      4'hF, 32'h0,      16'h0000);
        add(OP_RD,  BASE + 32'h00, 32'h0,         4'h0, 32'h0,      16'h0000);
        add(OP_WR,  BASE + 32'h10, 32'h0100,      4'hF, 32'h0,      16'h0000);
        add(OP_RD,  BASE + 32'h00, 32'h0,         4'h0, 32'h0100,   16'h0000);
        add(OP_RD,  BASE + 32'h10, 32'h0,         4'h0, 32'h0,      16'h0000);
        add(OP_WR,  BASE + 32'h04, 32'hFFFF_FFFF, 4'h1, 32'h0,      16'h0000);
        add(OP_RD,  BASE + 32'h04, 32'h0,         4'h0, 32'h00FF,   16'h0000);
        add(OP_WR,  BASE + 32'h04, 32'hFFFF_FFFF, 4'hE, 32'h0,      16'h0100);
        add(OP_RD,  BASE + 32'h04, 32'h0,         4'h0, 32'h0000_FFFF, 16'h0100);
        add(OP_RD,  BASE + 32'h08, 32'h0,         4'h0, 32'h0100,   16'h0100);
        add(OP_WR,  BASE + 32'h14, 32'hFFFF_FFFF, 4'hF, 32'h0,      16'h0100);
        add(OP_RD,  BASE + 32'h14, 32'h0,         4'h0, 32'h0,      16'h0100);
        add(OP_RD,  BASE + 32'h1C, 32'h0,         4'h0, 32'h0,      16'h0100);
        add(OP_RD,  BASE + 32'h0C, 32'h0,         4'h0, 32'h0,      16'h0100);
        add(OP_WR,  BASE + 32'h00, 32'h0100,      4'hF, 32'h0,      16'h0000);

        // Clock/reset.
        rst = 1'b1; src = '0; eoi = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_irq",       {16'b0, irq}, 32'h0);
        check("reset_mem_ready", {31'b0, mem_ready}, 32'h0);
        check("reset_mem_rdata", mem_rdata, 32'h0);

        // Address decode: out-of-window or invalid requests must not select.
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h0000_0000;
        #1 check("sel_addr_zero", {31'b0, sel}, 32'h0);
        mem_addr = 32'h1000_1000;
        #1 check("sel_next_page", {31'b0, sel}, 32'h0);
        mem_valid = 1'b0; mem_addr = BASE;
        #1 check("sel_no_valid", {31'b0, sel}, 32'h0);
        mem_valid = 1'b1; mem_addr = 32'h0000_0000;
        repeat (2) begin
            @(negedge clk);
            check("no_ready_unselected", {31'b0, mem_ready}, 32'h0);
        end
        mem_valid = 1'b0;

        // Table-driven vectors.
        foreach (tbl[i]) begin
            case (tbl[i].op)
                OP_WR: bus(1'b1, tbl[i].addr, tbl[i].data, tbl[i].strb, '0, rd);
                OP_RD: begin
                    exp_q.push_back(tbl[i].exp_rd);
                    bus(1'b0, tbl[i].addr, 32'h0, 4'h0, '0, rd);
                    check($sformatf("vec%0d_rdata", i), rd, exp_q.pop_front());
                end
                OP_SRC: begin
                    @(negedge clk) src = src | tbl[i].data[NS-1:0];
                    @(negedge clk) src = src & ~tbl[i].data[NS-1:0];
                    @(negedge clk);
                end
                default: begin
                    @(negedge clk) eoi = eoi | tbl[i].data[NS-1:0];
                    @(negedge clk) eoi = eoi & ~tbl[i].data[NS-1:0];
                    @(negedge clk);
                end
            endcase
            check($sformatf("vec%0d_irq", i), {16'b0, irq}, {16'b0, tbl[i].exp_irq});
        end

        // irq follows PENDING with one cycle of lag; a held eoi clears only once.
        @(negedge clk) src[0] = 1'b1;
        @(negedge clk) src[0] = 1'b0;
        check("irq_lag_before", {16'b0, irq}, 32'h0);
        @(negedge clk);
        check("irq_lag_after", {16'b0, irq}, 32'h1);
        eoi[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("eoi_clears", {16'b0, irq}, 32'h0);
        @(negedge clk) src[0] = 1'b1;
        @(negedge clk) src[0] = 1'b0;
        @(negedge clk);
        check("held_eoi_no_reclear", {16'b0, irq}, 32'h1);
        rd_chk("held_eoi_pending", OFF_PEND(), 32'h0001);
        eoi[0] = 1'b0;
        wr_reg(5'h00, 32'h0001);
        check("w1c_bit0_irq", {16'b0, irq}, 32'h0);

        // Coincident src edge and W1C on bit 5: the set must survive.
        bus(1'b1, BASE, 32'h0020, 4'hF, 16'h0020, rd);
        rd_chk("set_wins_w1c", 5'h00, 32'h0020);
        check("set_wins_w1c_irq", {16'b0, irq}, 32'h0020);
        wr_reg(5'h00, 32'h0020);

        // Coincident src edge and eoi edge on bit 6.
        @(negedge clk) begin src[6] = 1'b1; eoi[6] = 1'b1; end
        @(negedge clk) begin src[6] = 1'b0; eoi[6] = 1'b0; end
        rd_chk("set_wins_eoi", 5'h00, 32'h0040);
        wr_reg(5'h00, 32'h0040);
        rd_chk("w1c_bit6", 5'h00, 32'h0);

`ifdef IRQ_CTRL_LEVEL_EN
        wr_reg(5'h0C, 32'h0002);
        rd_chk("trigger_rd", 5'h0C, 32'h0002);
        @(negedge clk) src[1] = 1'b1;
        repeat (2) @(negedge clk);
        check("level_irq", {16'b0, irq}, 32'h0002);
        wr_reg(5'h00, 32'h0002);
        rd_chk("level_w1c_ignored", 5'h00, 32'h0002);
        @(negedge clk) src[1] = 1'b0;
        repeat (2) @(negedge clk);
        rd_chk("level_drop", 5'h00, 32'h0);
        check("level_drop_irq", {16'b0, irq}, 32'h0);
        wr_reg(5'h0C, 32'h0000);
`else
        wr_reg(5'h0C, 32'h0002);
        rd_chk("trigger_absent", 5'h0C, 32'h0);
        @(negedge clk) src[1] = 1'b1;
        repeat (2) @(negedge clk);
        check("edge_held_irq", {16'b0, irq}, 32'h0002);
        wr_reg(5'h00, 32'h0002);
        rd_chk("edge_held_w1c", 5'h00, 32'h0);
        @(negedge clk) src[1] = 1'b0;
`endif

        // Reset on the request edge aborts the access with no ready pulse.
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = BASE + 32'h04; mem_wstrb = 4'h0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_valid = 1'b0;
        check("abort_no_ready", {31'b0, mem_ready}, 32'h0);
        @(negedge clk);
        check("abort_no_ready_late", {31'b0, mem_ready}, 32'h0);
        rd_chk("abort_enable_reset", 5'h04, 32'h0);
        check("abort_irq_reset", {16'b0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic logic [4:0] OFF_PEND();
        return 5'h00;
    endfunction

endmodule
